// File: rtl/shift_serdes.sv
// shift_serdes: W-bit parallel-load shift register that serialises W-bit bursts.
// Define SHIFT_SERDES_ROTATE_EN to enable rotate mode (rot latched with start).
module shift_serdes #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] pin,
   input  logic         start,
   input  logic         dir,
   input  logic         sin,
   input  logic         rot,
   output logic         sout,
   output logic [W-1:0] pout,
   output logic         busy,
   output logic         done
);
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  reg_q, reg_d;
   logic          sout_q, sout_d;
   logic          done_q, done_d;
   logic          dir_q, dir_d;
   logic          out_bit, in_bit;

   assign out_bit = dir_q ? reg_q[W-1] : reg_q[0];

`ifdef SHIFT_SERDES_ROTATE_EN
   logic rot_q, rot_d;
   assign in_bit = rot_q ? out_bit : sin;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign in_bit     = sin;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      reg_d   = reg_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      dir_d   = dir_q;
`ifdef SHIFT_SERDES_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         IDLE: begin
            // load has priority; a simultaneous start is dropped
            if (load) begin
               reg_d = pin;
            end else if (start) begin
               dir_d   = dir;
`ifdef SHIFT_SERDES_ROTATE_EN
               rot_d   = rot;
`endif
               cnt_d   = CNT_FULL;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            reg_d  = dir_q ? {reg_q[W-2:0], in_bit} : {in_bit, reg_q[W-1:1]};
            sout_d = out_bit;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         reg_q   <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
         dir_q   <= 1'b0;
`ifdef SHIFT_SERDES_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
         dir_q   <= dir_d;
`ifdef SHIFT_SERDES_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

   assign sout = sout_q;
   assign pout = reg_q;
   assign busy = (state_q == SHIFT);
   assign done = done_q;

endmodule

// File: doc/shift_serdes.md
SHIFT_SERDES -- requirements
Module: shift_serdes

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning register width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port load, input, 1 bit: parallel-load request, honoured only in IDLE.
REQ-005 The block SHALL have port pin, input, W bits: parallel load data.
REQ-006 The block SHALL have port start, input, 1 bit: begin a W-bit shift burst, honoured only in IDLE.
REQ-007 The block SHALL have port dir, input, 1 bit: shift direction sampled with start; 0 = right (LSB out), 1 = left (MSB out).
REQ-008 The block SHALL have port sin, input, 1 bit: serial data in, sampled on every shift edge.
REQ-009 The block SHALL have port rot, input, 1 bit: rotate select, sampled with start; used only under the configuration macro.
REQ-010 The block SHALL have port sout, output, 1 bit: registered serial out, the bit most recently shifted out.
REQ-011 The block SHALL have port pout, output, W bits: current register contents.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-014 The FSM SHALL have two states, IDLE and SHIFT, with a shift counter of width clog2(W+1).
REQ-015 In IDLE with load=1, the edge SHALL set register <= pin and state stays IDLE.
REQ-016 In IDLE with start=1 and load=0, the edge SHALL latch dir/rot, set counter <= W, enter SHIFT, and leave the register unchanged.
REQ-017 In IDLE, load=1 with start=1 SHALL perform the load only and ignore start.
REQ-018 On each edge in SHIFT with dir=0, the register SHALL shift right, with sin entering at bit W-1 and sout <= old bit 0.
REQ-019 On each edge in SHIFT with dir=1, the register SHALL shift left, with sin entering at bit 0 and sout <= old bit W-1.
REQ-020 Each SHIFT edge SHALL decrement the counter; the edge on which the counter goes 1 -> 0 SHALL be the last shift, return the FSM to IDLE and set done=1 for exactly the following cycle.
REQ-021 Latency SHALL be: start sampled at edge k; shifts at edges k+1..k+W; busy high from after edge k until after edge k+W; done high from edge k+W to edge k+W+1.
REQ-022 In SHIFT, load and start SHALL be ignored, and dir/rot changes SHALL have no effect until the next burst.
REQ-023 A start sampled on the same edge that done is produced SHALL be ignored; a new start SHALL be accepted from the next IDLE cycle.
REQ-024 In IDLE without load, the register and sout SHALL hold.
REQ-025 pout SHALL equal the register at all times; no combinational path SHALL exist from inputs to any output.

Reset
REQ-026 On rst=1, the block SHALL immediately and asynchronously force register=0, sout=0, busy=0, done=0, counter=0 and state=IDLE.
REQ-027 Reset during SHIFT SHALL abort the burst with no done pulse; operation SHALL resume on the first edge after rst deasserts.

Configuration
REQ-028 With macro SHIFT_SERDES_ROTATE_EN defined and latched rot=1, the incoming bit on each shift SHALL be the bit shifted out (rotate), and sin SHALL be ignored.
REQ-029 With SHIFT_SERDES_ROTATE_EN undefined, the rot port SHALL remain present but be ignored, and sin SHALL always be used.

Verification (W=4)
REQ-030 Load pin=1011, then start dir=0, sin=0 -> sout 1,1,0,1; pout 0101,0010,0001,0000; done one cycle after the 4th shift edge.
REQ-031 Load 1011, then start dir=1, sin=1 -> sout 1,0,1,1; pout 0111,1111,1111,1111; busy high for exactly 4 cycles.
REQ-032 Load 1011 with macro defined, then start dir=0, rot=1 -> pout 1101,1110,0111,1011; sout 1,1,0,1; sin toggling has no effect.
REQ-033 load=1 and start=1 together in IDLE -> pout=pin, busy stays 0; a load pulse during SHIFT leaves the sequence unchanged.
REQ-034 Assert rst after 2 shifts -> outputs 0 immediately, no done; a fresh load/start then runs a normal 4-shift burst.
REQ-035 Hold start=1 continuously -> bursts of 4 shifts, with IDLE gap cycles between them and one done pulse per burst.
